// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control sequencer: opcodes, control-word bit
// indices, the inactive control word, microstep values and the per-opcode
// last active step.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned CW_W   = 16;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Opcodes; 9..D are unassigned and decode as NOP
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Control-word bit positions
  localparam int unsigned CW_HLT  = 0;
  localparam int unsigned CW_MI   = 1;
  localparam int unsigned CW_RI   = 2;
  localparam int unsigned CW_RO   = 3;
  localparam int unsigned CW_II   = 4;
  localparam int unsigned CW_IO   = 5;
  localparam int unsigned CW_AI   = 6;
  localparam int unsigned CW_AO   = 7;
  localparam int unsigned CW_BI   = 8;
  localparam int unsigned CW_SU   = 9;
  localparam int unsigned CW_EO_N = 10;
  localparam int unsigned CW_FI_N = 11;
  localparam int unsigned CW_OI   = 12;
  localparam int unsigned CW_CE   = 13;
  localparam int unsigned CW_CO   = 14;
  localparam int unsigned CW_J    = 15;

  // Everything idle: active-high lines low, the two active-low lines high
  localparam ctrl_word_t CW_INACTIVE = ctrl_word_t'((1 << CW_EO_N) | (1 << CW_FI_N));

  // Microsteps
  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // Final step that asserts anything for a given opcode
  function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_LDA, OP_STA:                        return T3;
      OP_ADD, OP_SUB:                        return T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_OUT, OP_HLT:                        return T2;
      default:                               return T1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/flag inputs, every control line
// and the debug step count.
//   master : sequencer side (drives control lines, reads OPCODE/CF/ZF)
//   slave  : datapath side
interface cpu_control_sequencer_if #(
  parameter int unsigned STEP_W = 3
);
  logic [3:0]        OPCODE;
  logic              CF;
  logic              ZF;
  logic              HLT;
  logic              MI;
  logic              RI;
  logic              RO;
  logic              II;
  logic              IO;
  logic              AI;
  logic              AO;
  logic              BI;
  logic              SU;
  logic              EO_n;
  logic              FI_n;
  logic              OI;
  logic              CE;
  logic              CO;
  logic              J;
  logic [STEP_W-1:0] STEP;

  modport master (
    input  OPCODE, CF, ZF,
    output HLT, MI, RI, RO, II, IO, AI, AO, BI, SU, EO_n, FI_n, OI, CE, CO, J, STEP
  );

  modport slave (
    output OPCODE, CF, ZF,
    input  HLT, MI, RI, RO, II, IO, AI, AO, BI, SU, EO_n, FI_n, OI, CE, CO, J, STEP
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational microcode decode: (opcode, step, flags, halted) -> control
// word plus a flag marking the opcode's last active step.
//   opcode, step, cf, zf, halted : decode inputs
//   cw                           : control word (bit layout from cpu_ctrl_pkg)
//   last                         : step is the opcode's last active step
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 3
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              cf,
  input  logic              zf,
  input  logic              halted,
  output ctrl_word_t        cw,
  output logic              last
);

  // Microcode table
  always_comb begin
    cw = CW_INACTIVE;
    if (halted) begin
      cw[CW_HLT] = 1'b1;
    end else begin
      case (step)
        STEP_W'(T0): begin
          cw[CW_CO] = 1'b1;
          cw[CW_MI] = 1'b1;
        end
        STEP_W'(T1): begin
          cw[CW_RO] = 1'b1;
          cw[CW_II] = 1'b1;
          cw[CW_CE] = 1'b1;
        end
        STEP_W'(T2): begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw[CW_IO] = 1'b1;
              cw[CW_MI] = 1'b1;
            end
            OP_LDI: begin
              cw[CW_IO] = 1'b1;
              cw[CW_AI] = 1'b1;
            end
            OP_JMP: begin
              cw[CW_IO] = 1'b1;
              cw[CW_J]  = 1'b1;
            end
            // Conditional jumps: a not-taken branch is an empty step
            OP_JC: begin
              cw[CW_IO] = cf;
              cw[CW_J]  = cf;
            end
            OP_JZ: begin
              cw[CW_IO] = zf;
              cw[CW_J]  = zf;
            end
            OP_OUT: begin
              cw[CW_AO] = 1'b1;
              cw[CW_OI] = 1'b1;
            end
            OP_HLT: cw[CW_HLT] = 1'b1;
            default: ;
          endcase
        end
        STEP_W'(T3): begin
          case (opcode)
            OP_LDA: begin
              cw[CW_RO] = 1'b1;
              cw[CW_AI] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RO] = 1'b1;
              cw[CW_BI] = 1'b1;
            end
            OP_STA: begin
              cw[CW_AO] = 1'b1;
              cw[CW_RI] = 1'b1;
            end
            default: ;
          endcase
        end
        STEP_W'(T4): begin
          // SU held for the whole step so sum and latched flags agree
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EO_N] = 1'b0;
            cw[CW_FI_N] = 1'b0;
            cw[CW_AI]   = 1'b1;
            cw[CW_SU]   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign last = (step == STEP_W'(last_step(opcode)));

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microstep sequencer for the 8-bit CPU: step counter, halt latch, reset
// gating and unpacking of the decoded control word onto the datapath bus.
//   CLK   : rising-edge clock
//   CLR_n : asynchronous active-low reset; forces all control lines inactive
//   bus   : OPCODE/CF/ZF in, all control lines and STEP out
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W    = 3,
  parameter bit          EARLY_END = 1'b1
) (
  input  logic                   CLK,
  input  logic                   CLR_n,
  cpu_control_sequencer_if.master bus
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_nxt;
  logic              halted_q;
  logic              halted_nxt;
  ctrl_word_t        cw_dec;
  ctrl_word_t        cw;
  logic              last;

  cpu_ctrl_decode #(.STEP_W(STEP_W)) u_decode (
    .opcode (bus.OPCODE),
    .step   (step_q),
    .cf     (bus.CF),
    .zf     (bus.ZF),
    .halted (halted_q),
    .cw     (cw_dec),
    .last   (last)
  );

  // State register
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_nxt;
      halted_q <= halted_nxt;
    end
  end

  // Next step: HLT freezes at T2, otherwise wrap early or after T4
  always_comb begin
    step_nxt   = step_q;
    halted_nxt = halted_q;
    if (!halted_q) begin
      if (step_q == STEP_W'(T2) && bus.OPCODE == OP_HLT) begin
        halted_nxt = 1'b1;
      end else if ((EARLY_END && last) || step_q == STEP_W'(T4)) begin
        step_nxt = '0;
      end else begin
        step_nxt = step_q + STEP_W'(1);
      end
    end
  end

  // Outputs: decoded word, forced idle while reset is held
  always_comb begin
    cw = CW_INACTIVE;
    if (CLR_n) begin
      cw = cw_dec;
    end
    bus.HLT  = cw[CW_HLT];
    bus.MI   = cw[CW_MI];
    bus.RI   = cw[CW_RI];
    bus.RO   = cw[CW_RO];
    bus.II   = cw[CW_II];
    bus.IO   = cw[CW_IO];
    bus.AI   = cw[CW_AI];
    bus.AO   = cw[CW_AO];
    bus.BI   = cw[CW_BI];
    bus.SU   = cw[CW_SU];
    bus.EO_n = cw[CW_EO_N];
    bus.FI_n = cw[CW_FI_N];
    bus.OI   = cw[CW_OI];
    bus.CE   = cw[CW_CE];
    bus.CO   = cw[CW_CO];
    bus.J    = cw[CW_J];
    bus.STEP = step_q;
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: one early-end instance and one fixed
// five-step instance, checked against an instruction-level microcode model.
module tb_cpu_control_sequencer;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  cpu_control_sequencer_if #(.STEP_W(3)) bus_e ();
  cpu_control_sequencer_if #(.STEP_W(3)) bus_f ();

  cpu_control_sequencer #(.STEP_W(3), .EARLY_END(1'b1)) dut_e (
    .CLK(clk), .CLR_n(clr_n), .bus(bus_e)
  );
  cpu_control_sequencer #(.STEP_W(3), .EARLY_END(1'b0)) dut_f (
    .CLK(clk), .CLR_n(clr_n), .bus(bus_f)
  );

  // Bench view of a control word: every line active-high
  localparam logic [15:0] M_HLT = 16'h0001, M_MI = 16'h0002, M_RI = 16'h0004,
                          M_RO  = 16'h0008, M_II = 16'h0010, M_IO = 16'h0020,
                          M_AI  = 16'h0040, M_AO = 16'h0080, M_BI = 16'h0100,
                          M_SU  = 16'h0200, M_EO = 16'h0400, M_FI = 16'h0800,
                          M_OI  = 16'h1000, M_CE = 16'h2000, M_CO = 16'h4000,
                          M_J   = 16'h8000;

  logic [15:0] act_e, act_f;
  assign act_e = {bus_e.J, bus_e.CO, bus_e.CE, bus_e.OI, ~bus_e.FI_n, ~bus_e.EO_n,
                  bus_e.SU, bus_e.BI, bus_e.AO, bus_e.AI, bus_e.IO, bus_e.II,
                  bus_e.RO, bus_e.RI, bus_e.MI, bus_e.HLT};
  assign act_f = {bus_f.J, bus_f.CO, bus_f.CE, bus_f.OI, ~bus_f.FI_n, ~bus_f.EO_n,
                  bus_f.SU, bus_f.BI, bus_f.AO, bus_f.AI, bus_f.IO, bus_f.II,
                  bus_f.RO, bus_f.RI, bus_f.MI, bus_f.HLT};

  int checks   = 0;
  int failures = 0;

  logic [15:0] seen_w [5];
  logic [2:0]  seen_s [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Microcode as written in the instruction set description
  function automatic logic [15:0] micro(input logic [3:0] op, input logic cf,
                                        input logic zf, input int t);
    logic [15:0] w;
    w = 16'h0000;
    if (t == 0) w = M_CO | M_MI;
    else if (t == 1) w = M_RO | M_II | M_CE;
    else if (t == 2) begin
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: w = M_IO | M_MI;
        4'h5: w = M_IO | M_AI;
        4'h6: w = M_IO | M_J;
        4'h7: w = cf ? (M_IO | M_J) : 16'h0000;
        4'h8: w = zf ? (M_IO | M_J) : 16'h0000;
        4'hE: w = M_AO | M_OI;
        4'hF: w = M_HLT;
        default: w = 16'h0000;
      endcase
    end else if (t == 3) begin
      case (op)
        4'h1: w = M_RO | M_AI;
        4'h2, 4'h3: w = M_RO | M_BI;
        4'h4: w = M_AO | M_RI;
        default: w = 16'h0000;
      endcase
    end else if (t == 4) begin
      if (op == 4'h2) w = M_EO | M_AI | M_FI;
      if (op == 4'h3) w = M_EO | M_AI | M_FI | M_SU;
    end
    return w;
  endfunction

  // Cycles per instruction; HLT stops counting once it reaches T2
  function automatic int inst_len(input bit sel, input logic [3:0] op);
    if (op == 4'hF) return 3;
    if (sel) return 5;
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic set_in(input bit sel, input logic [3:0] op, input logic cf, input logic zf);
    bus_e.OPCODE = sel ? 4'h0 : op;
    bus_e.CF     = sel ? 1'b0 : cf;
    bus_e.ZF     = sel ? 1'b0 : zf;
    bus_f.OPCODE = sel ? op : 4'h0;
    bus_f.CF     = sel ? cf : 1'b0;
    bus_f.ZF     = sel ? zf : 1'b0;
  endtask

  function automatic logic [15:0] cur_word(input bit sel);
    return sel ? act_f : act_e;
  endfunction

  function automatic logic [15:0] cur_step(input bit sel);
    return sel ? 16'(bus_f.STEP) : 16'(bus_e.STEP);
  endfunction

  // Entered just after an edge with the DUT in T0; leaves the same way
  task automatic play(input bit sel, input logic [3:0] op, input logic cf,
                      input logic zf, input int nsteps);
    set_in(sel, op, cf, zf);
    for (int t = 0; t < nsteps; t++) begin
      @(negedge clk);
      seen_w[t] = cur_word(sel);
      seen_s[t] = 3'(cur_step(sel));
      chk($sformatf("step d%0d op%h t%0d", sel, op, t), 16'(seen_s[t]), 16'(t));
      chk($sformatf("word d%0d op%h t%0d", sel, op, t), seen_w[t], micro(op, cf, zf, t));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #2;
    chk("rst_word_e", act_e, 16'h0000);
    chk("rst_step_e", 16'(bus_e.STEP), 16'h0000);
    chk("rst_word_f", act_f, 16'h0000);
    chk("rst_step_f", 16'(bus_f.STEP), 16'h0000);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic run_instr(input bit sel, input logic [3:0] op, input logic cf, input logic zf);
    play(sel, op, cf, zf, inst_len(sel, op));
    if (op == 4'hF) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk($sformatf("halt_step d%0d c%0d", sel, i), cur_step(sel), 16'd2);
        chk($sformatf("halt_word d%0d c%0d", sel, i), cur_word(sel), M_HLT);
        @(posedge clk);
        #1;
      end
      do_reset();
    end else begin
      chk($sformatf("boundary d%0d op%h", sel, op), cur_step(sel), 16'd0);
    end
  endtask

  initial begin
    set_in(1'b0, 4'h1, 1'b0, 1'b0);
    #1;
    do_reset();

    // LDA fetch/execute, pinned literally
    run_instr(1'b0, 4'h1, 1'b0, 1'b0);
    chk("lda_t0", seen_w[0], 16'h4002);
    chk("lda_t1", seen_w[1], 16'h2018);
    chk("lda_t2", seen_w[2], 16'h0022);
    chk("lda_t3", seen_w[3], 16'h0048);

    // SUB: SU only in T4, together with EO/FI/AI
    run_instr(1'b0, 4'h3, 1'b0, 1'b0);
    chk("sub_t4", seen_w[4], 16'h0E40);
    chk("sub_t3_su", 16'(seen_w[3][9]), 16'h0000);

    // JC not taken then taken
    run_instr(1'b0, 4'h7, 1'b0, 1'b1);
    chk("jc0_t2", seen_w[2], 16'h0000);
    run_instr(1'b0, 4'h7, 1'b1, 1'b0);
    chk("jc1_t2", seen_w[2], 16'h8020);
    run_instr(1'b0, 4'h8, 1'b0, 1'b1);

    // HLT latches, then reset recovers
    run_instr(1'b0, 4'hF, 1'b0, 1'b0);
    run_instr(1'b0, 4'h0, 1'b0, 1'b0);

    // Reset in the middle of ADD T3
    play(1'b0, 4'h2, 1'b0, 1'b0, 3);
    @(negedge clk);
    chk("add_t3_pre", act_e, 16'h0108);
    #1;
    clr_n = 1'b0;
    #1;
    chk("midrst_word", act_e, 16'h0000);
    chk("midrst_step", 16'(bus_e.STEP), 16'h0000);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    run_instr(1'b0, 4'h6, 1'b0, 1'b0);
    chk("after_midrst_t0", seen_w[0], 16'h4002);

    // Fixed five-step instance with LDI
    do_reset();
    run_instr(1'b1, 4'h5, 1'b0, 1'b0);
    chk("ldi_ff_t3", seen_w[3], 16'h0000);
    chk("ldi_ff_t4", seen_w[4], 16'h0000);
    chk("ldi_ff_s4", 16'(seen_s[4]), 16'd4);
    chk("ldi_ff_t2", seen_w[2], 16'h0060);

    // Random instruction streams on both instances
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      for (int n = 0; n < 120; n++) begin
        run_instr(sel[0], 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
